// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Transaction-based icache/dcache arbiter for a single RAM port.
//           Dcache has priority; a long-waiting icache overrides it.
//           Define ARB_PERF_EN to add word and override counters.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int MAX_BURST  = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
`ifdef ARB_PERF_EN
    output logic [31:0]       icnt,
    output logic [31:0]       dcnt,
    output logic [31:0]       scnt,
`endif
    input  logic [1:0]        ramstate
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [1:0]    c_RS_ACCESS  = 2'd2;
    localparam logic [BW-1:0] c_BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [SW-1:0] c_STARVE_LIM = SW'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [SW-1:0]   starve_q, starve_d;

    logic w_dreq, w_gnt_i, w_gnt_d, w_strobe, w_done, w_req, w_override;

    assign w_dreq     = dREN | dWEN;
    assign w_gnt_i    = (state_q == IGNT);
    assign w_gnt_d    = (state_q == DGNT);
    assign w_strobe   = (w_gnt_i & iREN) | (w_gnt_d & w_dreq);
    assign w_done     = w_strobe && (ramstate == c_RS_ACCESS);
    assign w_req      = w_gnt_i ? iREN : w_dreq;
    assign w_override = (state_q == IDLE) && w_dreq && iREN && (starve_q >= c_STARVE_LIM);

    // RAM side forwards the granted requester; ERROR never completes a word.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        if (w_gnt_i) begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (w_done) begin
                iwait = 1'b0;
                iload = ramload;
            end
        end else if (w_gnt_d) begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (w_done) begin
                dwait = 1'b0;
                dload = ramload;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (w_dreq && (starve_q < c_STARVE_LIM)) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT, DGNT: begin
                if (!w_req || (w_done && (burst_q == c_BURST_LAST))) begin
                    state_d = IDLE;
                    burst_d = '0;
                end else if (w_done) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
        if (!iREN || (state_d == IGNT)) begin
            starve_d = '0;
        end else if ((state_q != IGNT) && (starve_q < c_STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            starve_q <= '0;
`ifdef ARB_PERF_EN
            icnt     <= '0;
            dcnt     <= '0;
            scnt     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            starve_q <= starve_d;
`ifdef ARB_PERF_EN
            if (w_done && w_gnt_i) icnt <= icnt + 32'd1;
            if (w_done && w_gnt_d) dcnt <= dcnt + 32'd1;
            if (w_override)        scnt <= scnt + 32'd1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter (ARB_PERF_EN aware).
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_PERF_EN
    logic [31:0] icnt, dcnt, scnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(32), .MAX_BURST(2), .STARVE_LIM(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload),
`ifdef ARB_PERF_EN
        .icnt(icnt), .dcnt(dcnt), .scnt(scnt),
`endif
        .ramstate(ramstate)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are checked mid-cycle.
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    initial begin
        nRST = 1'b1; iREN = 1'b1; iaddr = 32'h100;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramload = 32'hDEAD; ramstate = FREE;

        // Reset with icache requesting
        repeat (2) @(posedge CLK);
        #1; mid();
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_iwait",  {31'd0, iwait},  32'd1);
        chk("rst_dwait",  {31'd0, dwait},  32'd1);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_iload",   iload,   32'd0);
        nxt(); nRST = 1'b0; mid();
        chk("t1_idle_ren", {31'd0, ramREN}, 32'd0);
        nxt(); mid();
        chk("t1_ign_ren",  {31'd0, ramREN}, 32'd1);
        chk("t1_ign_addr", ramaddr, 32'h100);
        chk("t1_ign_wait", {31'd0, iwait}, 32'd1);
        ramstate = ACC; ramload = 32'h11; #1;
        chk("t1_iwait0", {31'd0, iwait}, 32'd0);
        chk("t1_iload",  iload, 32'h11);
        nxt(); iREN = 1'b0; ramstate = FREE;
        nxt();

        // Both request in IDLE: dcache wins, 2-word burst, then icache
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; mid();
        chk("t2_idle_ren", {31'd0, ramREN}, 32'd0);
        nxt(); ramstate = ACC; ramload = 32'hA1; mid();
        chk("t2_w1_dwait", {31'd0, dwait}, 32'd0);
        chk("t2_w1_dload", dload, 32'hA1);
        chk("t2_w1_iwait", {31'd0, iwait}, 32'd1);
        chk("t2_w1_iload", iload, 32'd0);
        chk("t2_w1_addr",  ramaddr, 32'h200);
        nxt(); ramload = 32'hA2; mid();
        chk("t2_w2_dwait", {31'd0, dwait}, 32'd0);
        chk("t2_w2_dload", dload, 32'hA2);
        nxt(); dREN = 1'b0; ramstate = FREE; mid();
        chk("t2_idle_ren2", {31'd0, ramREN}, 32'd0);
        chk("t2_idle_dw",   {31'd0, dwait},  32'd1);
        nxt(); mid();
        chk("t2_ign_ren",  {31'd0, ramREN}, 32'd1);
        chk("t2_ign_addr", ramaddr, 32'h100);
        nxt(); iREN = 1'b0;
        nxt();

        // Dcache burst with BUSY,ACCESS,BUSY,ACCESS
        dREN = 1'b1; daddr = 32'h300;
        nxt(); ramstate = BUSY; mid();
        chk("t3_c1_dwait", {31'd0, dwait}, 32'd1);
        nxt(); ramstate = ACC; ramload = 32'hB2; mid();
        chk("t3_c2_dwait", {31'd0, dwait}, 32'd0);
        chk("t3_c2_dload", dload, 32'hB2);
        nxt(); ramstate = BUSY; mid();
        chk("t3_c3_dwait", {31'd0, dwait}, 32'd1);
        chk("t3_c3_dload", dload, 32'd0);
        nxt(); ramstate = ACC; ramload = 32'hB4; mid();
        chk("t3_c4_dwait", {31'd0, dwait}, 32'd0);
        nxt(); dREN = 1'b0; ramstate = FREE; mid();
        chk("t3_rel_ren",  {31'd0, ramREN}, 32'd0);
        chk("t3_rel_dw",   {31'd0, dwait},  32'd1);
        nxt();

        // Starvation override: icache waits 8 cycles behind dcache
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h400;
        nxt(); ramstate = BUSY;
        repeat (6) nxt();
        ramstate = ACC; ramload = 32'hC1;
        nxt(); mid();
        chk("t4_dgnt_addr", ramaddr, 32'h400);
        nxt(); ramstate = FREE; mid();
        chk("t4_idle_ren", {31'd0, ramREN}, 32'd0);
        nxt(); mid();
        chk("t4_ovr_ren",  {31'd0, ramREN}, 32'd1);
        chk("t4_ovr_addr", ramaddr, 32'h100);
        chk("t4_ovr_dw",   {31'd0, dwait},  32'd1);
`ifdef ARB_PERF_EN
        chk("t4_scnt", scnt, 32'd1);
        chk("t4_icnt", icnt, 32'd1);
        chk("t4_dcnt", dcnt, 32'd6);
`endif
        dREN = 1'b0; iREN = 1'b0;
        nxt(); nxt();

        // ERROR retries on a write, then a read in the same grant
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'h55;
        for (int k = 0; k < 3; k++) begin
            nxt(); ramstate = ERR; mid();
            chk("t5_err_dwait", {31'd0, dwait},  32'd1);
            chk("t5_err_wen",   {31'd0, ramWEN}, 32'd1);
            chk("t5_err_addr",  ramaddr, 32'h40);
        end
        nxt(); ramstate = ACC; mid();
        chk("t5_acc_dwait", {31'd0, dwait}, 32'd0);
        chk("t5_acc_store", ramstore, 32'h55);
        chk("t5_acc_addr",  ramaddr, 32'h40);
        nxt(); dWEN = 1'b0; dREN = 1'b1; daddr = 32'h44; ramload = 32'hC4; mid();
        chk("t5_rd_dwait", {31'd0, dwait}, 32'd0);
        chk("t5_rd_dload", dload, 32'hC4);
        chk("t5_rd_wen",   {31'd0, ramWEN}, 32'd0);
        nxt(); dREN = 1'b0; ramstate = FREE; mid();
        chk("t5_rel_ren", {31'd0, ramREN}, 32'd0);
        nxt();

        // Reset mid-burst: grant dropped and burst count cleared
        dWEN = 1'b1; daddr = 32'h80;
        nxt(); ramstate = ACC; mid();
        chk("t6_w1_dwait", {31'd0, dwait}, 32'd0);
        nxt(); nRST = 1'b1; ramstate = BUSY;
        nxt(); nRST = 1'b0; mid();
        chk("t6_rst_wen",  {31'd0, ramWEN}, 32'd0);
        chk("t6_rst_ren",  {31'd0, ramREN}, 32'd0);
        chk("t6_rst_dw",   {31'd0, dwait},  32'd1);
        nxt(); ramstate = ACC; mid();
        chk("t6_r1_dwait", {31'd0, dwait}, 32'd0);
        nxt(); mid();
        chk("t6_r2_wen",   {31'd0, ramWEN}, 32'd1);
        chk("t6_r2_dwait", {31'd0, dwait},  32'd0);
        nxt(); dWEN = 1'b0; ramstate = FREE; mid();
        chk("t6_rel_wen",  {31'd0, ramWEN}, 32'd0);
`ifdef ARB_PERF_EN
        chk("t6_dcnt", dcnt, 32'd2);
        chk("t6_scnt", scnt, 32'd0);
`endif
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
